// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and flush-to-bubble conversion.
// Define IDEX_PERF_CNT_EN to add the bubble_cnt/flush_cnt performance counters.
module idex_pipe_reg #(
   parameter int XLEN     = 32,
   parameter int REGIDX_W = 5
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                hold,
   input  logic                flush,
   input  logic                id_valid,
   input  logic                id_RegWrite,
   input  logic                id_MemWrite,
   input  logic                id_MemRead,
   input  logic [4:0]          id_ALUOp,
   input  logic [4:0]          id_NPCOp,
   input  logic                id_ALUSrc,
   input  logic [1:0]          id_WDSel,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [XLEN-1:0]     id_pc,
   input  logic [XLEN-1:0]     id_rd1,
   input  logic [XLEN-1:0]     id_rd2,
   input  logic [XLEN-1:0]     id_imm,
   input  logic [REGIDX_W-1:0] id_rs1,
   input  logic [REGIDX_W-1:0] id_rs2,
   input  logic [REGIDX_W-1:0] id_rd,
   output logic                ex_valid,
   output logic                ex_RegWrite,
   output logic                ex_MemWrite,
   output logic                ex_MemRead,
   output logic [4:0]          ex_ALUOp,
   output logic [4:0]          ex_NPCOp,
   output logic                ex_ALUSrc,
   output logic [1:0]          ex_WDSel,
   output logic [XLEN-1:0]     ex_pc,
   output logic [XLEN-1:0]     ex_rd1,
   output logic [XLEN-1:0]     ex_rd2,
   output logic [XLEN-1:0]     ex_imm,
   output logic [REGIDX_W-1:0] ex_rs1,
   output logic [REGIDX_W-1:0] ex_rs2,
   output logic [REGIDX_W-1:0] ex_rd,
`ifdef IDEX_PERF_CNT_EN
   output logic [31:0]         bubble_cnt,
   output logic [31:0]         flush_cnt,
`endif
   output logic                lu_stall
);

   logic haz;
   logic bubble;

   // A load writing x0 never produces a value worth waiting for.
   assign haz = id_valid & ex_valid & ex_MemRead & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   assign lu_stall = haz & ~flush & ~hold;
   assign bubble   = flush | haz | ~id_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_valid    <= 1'b0;
         ex_RegWrite <= 1'b0;
         ex_MemWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_ALUOp    <= '0;
         ex_NPCOp    <= '0;
         ex_ALUSrc   <= 1'b0;
         ex_WDSel    <= '0;
         ex_pc       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
      end else if (!hold) begin
         // Data and index fields always follow ID; only control is squashed on a bubble.
         ex_pc  <= id_pc;
         ex_rd1 <= id_rd1;
         ex_rd2 <= id_rd2;
         ex_imm <= id_imm;
         ex_rs1 <= id_rs1;
         ex_rs2 <= id_rs2;
         ex_rd  <= id_rd;
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_ALUOp    <= '0;
            ex_NPCOp    <= '0;
            ex_ALUSrc   <= 1'b0;
            ex_WDSel    <= '0;
         end else begin
            ex_valid    <= 1'b1;
            ex_RegWrite <= id_RegWrite;
            ex_MemWrite <= id_MemWrite;
            ex_MemRead  <= id_MemRead;
            ex_ALUOp    <= id_ALUOp;
            ex_NPCOp    <= id_NPCOp;
            ex_ALUSrc   <= id_ALUSrc;
            ex_WDSel    <= id_WDSel;
         end
      end
   end

`ifdef IDEX_PERF_CNT_EN
   // Flush takes precedence, so a squashed hazard is counted only as a flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (!hold) begin
         if (flush)
            flush_cnt <= flush_cnt + 32'd1;
         else if (haz)
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule
